// File: rtl/mmc_command_sequencer_pkg.sv
// Shared types and helpers for the SPI-mode MMC/SD command sequencer.
//   state_t      : top-level command sequencing states
//   xfer_t       : byte-transfer handshake sub-states (shared by every state)
//   MMC_*        : framing constants for the command token and idle bus byte
//   crc7_update  : folds one byte into a running CRC7 (x^7 + x^3 + 1, MSB first)
package mmc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        PRE,
        CMD,
        POLL,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        XFER_LAUNCH,
        XFER_SKIP,
        XFER_WAIT
    } xfer_t;

    localparam logic [1:0] MMC_START_BITS = 2'b01;
    localparam logic [7:0] MMC_IDLE_BYTE  = 8'hFF;
    localparam logic [6:0] CRC7_POLY      = 7'h09;

    // Bit-serial CRC7, most significant data bit first; the x^7 term is implicit.
    function automatic logic [6:0] crc7_update(input logic [6:0] crc, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ CRC7_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/mmc_command_sequencer_if.sv
// Byte-level bus between the command sequencer and the SPI byte engine.
//   send_data : byte to shift out on MOSI
//   start     : one-cycle request to transfer send_data
//   busy      : engine busy; rises the cycle after start, falls when the byte is done
//   recv_data : byte shifted in on MISO, valid once busy falls
// master = sequencer, slave = SPI byte engine.
interface mmc_command_sequencer_if;
    logic [7:0] send_data;
    logic       start;
    logic       busy;
    logic [7:0] recv_data;

    modport master (output send_data, output start, input busy, input recv_data);
    modport slave  (input send_data, input start, output busy, output recv_data);
endinterface

// File: rtl/mmc_command_sequencer.sv
// Issues one SPI-mode MMC/SD command frame and collects the R1 response.
// Frame: CS assert, PRE_DUMMY idle bytes, 6-byte command (CRC7 generated here),
// then up to NCR_MAX 0xFF polls until a byte with bit7 == 0 comes back.
// Ports:
//   clock, reset_n    : system clock, asynchronous active-low reset
//   cmd_start         : one-cycle request, honoured only in IDLE
//   cmd_index/arg     : command index and 32-bit argument (MSB first on the wire)
//   cmd_keep_cs       : leave mmc_cs_n low after completion for a data phase
//   cmd_busy          : high from the cycle after an accepted start until done
//   cmd_done          : one-cycle completion pulse
//   cmd_timeout       : no response within NCR_MAX polls (valid with cmd_done)
//   cmd_response      : R1 byte, or the last polled byte on timeout
//   mmc_cs_n          : card chip select, active low
//   spi               : byte-engine bus (this block is the only master)
module mmc_command_sequencer
    import mmc_pkg::*;
#(
    parameter int NCR_MAX   = 8,
    parameter int PRE_DUMMY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        cmd_keep_cs,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        cmd_timeout,
    output logic [7:0]  cmd_response,
    output logic        mmc_cs_n,
    mmc_command_sequencer_if.master spi
);

    state_t      state;
    xfer_t       xfer;
    logic [5:0]  index_q;
    logic [31:0] arg_q;
    logic        keep_q;
    logic [6:0]  crc;
    logic [3:0]  byte_cnt;
    logic [7:0]  poll_cnt;

    logic [7:0]  cmd_byte;
    logic [7:0]  tx_byte;
    logic [7:0]  poll_next;

    // Byte to launch next. The CRC byte reads the register that was updated
    // while the previous five bytes were launched, so it is complete by then.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cmd_byte = MMC_IDLE_BYTE;
        case (byte_cnt)
            4'd0:    cmd_byte = {MMC_START_BITS, index_q};
            4'd1:    cmd_byte = arg_q[31:24];
            4'd2:    cmd_byte = arg_q[23:16];
            4'd3:    cmd_byte = arg_q[15:8];
            4'd4:    cmd_byte = arg_q[7:0];
            4'd5:    cmd_byte = {crc, 1'b1};
            default: cmd_byte = MMC_IDLE_BYTE;
        endcase

        tx_byte   = (state == CMD) ? cmd_byte : MMC_IDLE_BYTE;
        // Saturating poll count: NCR_MAX may be 255, so the count must never wrap to 0.
        poll_next = (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            xfer          <= XFER_LAUNCH;
            index_q       <= '0;
            arg_q         <= '0;
            keep_q        <= 1'b0;
            crc           <= '0;
            byte_cnt      <= '0;
            poll_cnt      <= '0;
            cmd_busy      <= 1'b0;
            cmd_done      <= 1'b0;
            cmd_timeout   <= 1'b0;
            cmd_response  <= MMC_IDLE_BYTE;
            mmc_cs_n      <= 1'b1;
            spi.start     <= 1'b0;
            spi.send_data <= MMC_IDLE_BYTE;
        end else begin
            cmd_done  <= 1'b0;
            spi.start <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        index_q      <= cmd_index;
                        arg_q        <= cmd_arg;
                        keep_q       <= cmd_keep_cs;
                        cmd_timeout  <= 1'b0;
                        cmd_response <= MMC_IDLE_BYTE;
                        cmd_busy     <= 1'b1;
                        // Already low when the previous command kept CS: no glitch.
                        mmc_cs_n     <= 1'b0;
                        crc          <= '0;
                        byte_cnt     <= '0;
                        poll_cnt     <= '0;
                        xfer         <= XFER_LAUNCH;
                        state        <= CS_SETUP;
                    end
                end

                // One cycle of CS setup before the first clock edge on SCK.
                CS_SETUP: state <= (PRE_DUMMY == 0) ? CMD : PRE;

                PRE, CMD, POLL: begin
                    case (xfer)
                        XFER_LAUNCH: begin
                            if (!spi.busy) begin
                                spi.send_data <= tx_byte;
                                spi.start     <= 1'b1;
                                if (state == CMD && byte_cnt < 4'd5)
                                    crc <= crc7_update(crc, cmd_byte);
                                xfer <= XFER_SKIP;
                            end
                        end

                        // Engine raises busy one cycle after start; busy is still low here.
                        XFER_SKIP: xfer <= XFER_WAIT;

                        XFER_WAIT: begin
                            if (!spi.busy) begin
                                spi.send_data <= MMC_IDLE_BYTE;
                                xfer          <= XFER_LAUNCH;
                                case (state)
                                    PRE: begin
                                        if (byte_cnt == 4'(PRE_DUMMY - 1)) begin
                                            byte_cnt <= '0;
                                            state    <= CMD;
                                        end else begin
                                            byte_cnt <= byte_cnt + 4'd1;
                                        end
                                    end
                                    CMD: begin
                                        if (byte_cnt == 4'd5) begin
                                            byte_cnt <= '0;
                                            state    <= POLL;
                                        end else begin
                                            byte_cnt <= byte_cnt + 4'd1;
                                        end
                                    end
                                    default: begin
                                        poll_cnt <= poll_next;
                                        // Response takes priority, so an answer on the
                                        // last allowed poll still counts as success.
                                        if (!spi.recv_data[7]) begin
                                            cmd_response <= spi.recv_data;
                                            cmd_timeout  <= 1'b0;
                                            state        <= DONE;
                                        end else if (poll_next >= 8'(NCR_MAX)) begin
                                            cmd_response <= spi.recv_data;
                                            cmd_timeout  <= 1'b1;
                                            state        <= DONE;
                                        end
                                    end
                                endcase
                            end
                        end

                        default: xfer <= XFER_LAUNCH;
                    endcase
                end

                DONE: begin
                    cmd_done <= 1'b1;
                    cmd_busy <= 1'b0;
                    if (!keep_q) mmc_cs_n <= 1'b1;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmc_command_sequencer.sv
// Self-checking bench for mmc_command_sequencer: a behavioural SPI byte engine
// plus card model answers polls; expected MOSI bytes go into a scoreboard queue
// when each command is issued and are compared against the bytes the engine saw.
module tb_mmc_command_sequencer;

    localparam int NCR_MAX   = 8;
    localparam int PRE_DUMMY = 1;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_keep_cs;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_timeout;
    logic [7:0]  cmd_response;
    logic        mmc_cs_n;

    mmc_command_sequencer_if spi_bus ();

    mmc_command_sequencer #(.NCR_MAX(NCR_MAX), .PRE_DUMMY(PRE_DUMMY)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cmd_start    (cmd_start),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .cmd_keep_cs  (cmd_keep_cs),
        .cmd_busy     (cmd_busy),
        .cmd_done     (cmd_done),
        .cmd_timeout  (cmd_timeout),
        .cmd_response (cmd_response),
        .mmc_cs_n     (mmc_cs_n),
        .spi          (spi_bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // ---------------- SPI byte engine + card model ----------------
    logic [7:0] obs_q[$];
    int         byte_total = 0;
    int         frame_base = 0;
    int         resp_at    = 0;
    logic [7:0] resp_byte  = 8'hFF;
    logic [1:0] eng_cnt;
    logic [7:0] miso_next;

    // Card answers resp_byte on poll number resp_at (1-based); 0 means never.
    function automatic logic [7:0] card_byte(input int idx);
        int poll;
        poll = idx - (PRE_DUMMY + 6) + 1;
        if (resp_at != 0 && poll == resp_at) return resp_byte;
        return 8'hFF;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            spi_bus.busy      <= 1'b0;
            spi_bus.recv_data <= 8'hFF;
            eng_cnt           <= 2'd0;
            miso_next         <= 8'hFF;
        end else if (spi_bus.busy) begin
            if (eng_cnt == 2'd0) begin
                spi_bus.busy      <= 1'b0;
                spi_bus.recv_data <= miso_next;
            end else begin
                eng_cnt <= eng_cnt - 2'd1;
            end
        end else if (spi_bus.start) begin
            obs_q.push_back(spi_bus.send_data);
            miso_next    <= card_byte(byte_total - frame_base);
            byte_total   <= byte_total + 1;
            spi_bus.busy <= 1'b1;
            eng_cnt      <= 2'd2;
        end
    end

    int done_count = 0;
    always @(negedge clock) if (cmd_done === 1'b1) done_count <= done_count + 1;

    // ---------------- reference CRC7 (polynomial long division) ----------------
    function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    logic [7:0] exp_q[$];
    int         rd        = 0;
    logic       last_keep = 1'b0;

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic keep,
                           input int ans_at, input logic [7:0] ans, input logic poke);
        logic [39:0] msg;
        logic [7:0]  e;
        int          polls;
        int          done_before;
        int          k;
        logic        got;
        logic        cs_hi;
        logic        poked;

        check("cs_before_start", 32'(mmc_cs_n), last_keep ? 32'd0 : 32'd1);
        msg        = {2'b01, idx, arg};
        frame_base = byte_total;
        resp_at    = ans_at;
        resp_byte  = ans;
        for (int i = 0; i < PRE_DUMMY; i++) exp_q.push_back(8'hFF);
        for (int i = 0; i < 5; i++) exp_q.push_back(msg[39 - 8*i -: 8]);
        exp_q.push_back({ref_crc7(msg), 1'b1});
        polls = (ans_at == 0) ? NCR_MAX : ans_at;
        for (int i = 0; i < polls; i++) exp_q.push_back(8'hFF);
        done_before = done_count;

        cmd_index   = idx;
        cmd_arg     = arg;
        cmd_keep_cs = keep;
        cmd_start   = 1'b1;
        @(negedge clock);
        cmd_start   = 1'b0;
        check("busy_after_start", 32'(cmd_busy), 32'd1);
        // Scramble inputs: the frame must come from the latched copies.
        cmd_index   = ~idx;
        cmd_arg     = ~arg;
        cmd_keep_cs = ~keep;

        got   = 1'b0;
        cs_hi = 1'b0;
        poked = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (cmd_done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (mmc_cs_n !== 1'b0) cs_hi = 1'b1;
            cmd_start = poke && !poked && ((byte_total - frame_base) > PRE_DUMMY + 6);
            if (cmd_start) poked = 1'b1;
            @(negedge clock);
        end
        cmd_start = 1'b0;

        check("done_seen", 32'(got), 32'd1);
        check("cs_low_during_cmd", 32'(cs_hi), 32'd0);
        check("busy_at_done", 32'(cmd_busy), 32'd0);
        check("response", 32'(cmd_response), (ans_at != 0) ? 32'(ans) : 32'hFF);
        check("timeout", 32'(cmd_timeout), (ans_at == 0) ? 32'd1 : 32'd0);
        check("cs_at_done", 32'(mmc_cs_n), keep ? 32'd0 : 32'd1);

        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd < obs_q.size()) begin
                check($sformatf("mosi[%0d]", k), 32'(obs_q[rd]), 32'(e));
                rd++;
            end else begin
                check($sformatf("mosi_missing[%0d]", k), 32'd0, 32'd1);
            end
            k++;
        end
        check("mosi_extra", 32'(obs_q.size() - rd), 32'd0);
        rd = obs_q.size();

        @(negedge clock);
        check("done_one_cycle", 32'(cmd_done), 32'd0);
        repeat (10) @(negedge clock);
        check("done_count", 32'(done_count - done_before), 32'd1);
        check("idle_busy", 32'(cmd_busy), 32'd0);
        check("cs_idle", 32'(mmc_cs_n), keep ? 32'd0 : 32'd1);
        check("idle_send_data", 32'(spi_bus.send_data), 32'hFF);
        last_keep = keep;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(cmd_busy), 32'd0);
        check({tag, "_done"}, 32'(cmd_done), 32'd0);
        check({tag, "_timeout"}, 32'(cmd_timeout), 32'd0);
        check({tag, "_response"}, 32'(cmd_response), 32'hFF);
        check({tag, "_cs_n"}, 32'(mmc_cs_n), 32'd1);
        check({tag, "_spi_start"}, 32'(spi_bus.start), 32'd0);
        check({tag, "_send_data"}, 32'(spi_bus.send_data), 32'hFF);
    endtask

    initial begin
        int   waited;
        logic reached;

        cmd_start   = 1'b0;
        cmd_index   = '0;
        cmd_arg     = '0;
        cmd_keep_cs = 1'b0;
        reset_n     = 1'b1;
        #2 reset_n  = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run_cmd(6'd0,  32'h0000_0000, 1'b0, 2, 8'h01, 1'b0);       // CMD0
        run_cmd(6'd8,  32'h0000_01AA, 1'b0, 1, 8'h01, 1'b0);       // CMD8
        run_cmd(6'd58, 32'h0000_0000, 1'b0, 0, 8'hFF, 1'b0);       // timeout
        run_cmd(6'd17, 32'h0000_1000, 1'b1, 3, 8'h00, 1'b0);       // keep CS
        run_cmd(6'd16, 32'h0000_0200, 1'b0, 1, 8'h00, 1'b0);       // starts with CS low
        run_cmd(6'd13, 32'hDEAD_BEEF, 1'b0, 4, 8'h00, 1'b1);       // start during POLL
        run_cmd(6'd55, 32'h8000_0001, 1'b0, NCR_MAX, 8'h05, 1'b0); // answer on last poll

        // Reset during the transfer of command byte 3.
        frame_base  = byte_total;
        resp_at     = 1;
        resp_byte   = 8'h01;
        cmd_index   = 6'd17;
        cmd_arg     = 32'h1234_5678;
        cmd_keep_cs = 1'b0;
        cmd_start   = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
        reached   = 1'b0;
        waited    = 0;
        while (waited < 500 && !reached) begin
            if ((byte_total - frame_base) >= PRE_DUMMY + 4 && spi_bus.busy === 1'b1) reached = 1'b1;
            else begin
                @(negedge clock);
                waited++;
            end
        end
        check("reached_cmd_byte3", 32'(reached), 32'd1);
        check("busy_mid_cmd", 32'(cmd_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        rd = obs_q.size();
        repeat (3) @(negedge clock);
        reset_n   = 1'b1;
        last_keep = 1'b0;
        @(negedge clock);
        run_cmd(6'd0, 32'h0000_0000, 1'b0, 2, 8'h01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
